// File: rtl/noc_run_monitor_if.sv
// Signal bundle between a torus NoC harness and its run monitor.
// The master side drives the arm/done/strobe/read-index inputs; the slave side is the monitor.
interface noc_run_monitor_if #(
    parameter int N_NODES = 16,
    parameter int NODE_W  = 4,
    parameter int CNT_W   = 16
) ();
    logic               start;
    logic               done;
    logic [N_NODES-1:0] out_v;
    logic [NODE_W-1:0]  rd_node;
    logic [CNT_W-1:0]   rd_count;
    logic [CNT_W-1:0]   total;
    logic [CNT_W-1:0]   cycles;
    logic [2:0]         status;
    logic               finish;
    logic               ovf;

    modport master (
        output start, done, out_v, rd_node,
        input  rd_count, total, cycles, status, finish, ovf
    );

    modport slave (
        input  start, done, out_v, rd_node,
        output rd_count, total, cycles, status, finish, ovf
    );
endinterface

// File: rtl/noc_run_monitor.sv
// Run monitor for torus NoC runs: counts cycles and per-node/total delivered packets,
// then reports PASS / FAIL_COUNT / FAIL_TIMEOUT once `done` is stable or time runs out.
module noc_run_monitor #(
    parameter int N_NODES  = 16,
    parameter int NODE_W   = 4,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1024,
    parameter int STABLE   = 2,
    parameter int EXP_PKTS = 192
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_run_monitor_if.slave     bus
);
    localparam int POP_W = $clog2(N_NODES + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_RUN  = 3'b001,
        S_PASS = 3'b010,
        S_FCNT = 3'b011,
        S_FTO  = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N_NODES];
    logic [CNT_W-1:0] cnt_d [N_NODES];
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [7:0]       stab_q, stab_d;
    logic             ovf_q, ovf_d;
    logic             finish_q, finish_d;

    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;
    logic             complete;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            for (int unsigned i = 0; i < N_NODES; i++) cnt_q[i] <= '0;
            total_q  <= '0;
            cycles_q <= '0;
            stab_q   <= '0;
            ovf_q    <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            cycles_q <= cycles_d;
            stab_q   <= stab_d;
            ovf_q    <= ovf_d;
            finish_q <= finish_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        cycles_d = cycles_q;
        stab_d   = stab_q;
        ovf_d    = ovf_q;
        finish_d = 1'b0;
        pop      = '0;
        sum      = '0;
        complete = 1'b0;
        timeout  = 1'b0;

        case (state_q)
            S_RUN: begin
                if (cycles_q == '1) ovf_d = 1'b1;
                else                cycles_d = cycles_q + CNT_W'(1);

                for (int unsigned i = 0; i < N_NODES; i++) begin
                    if (bus.out_v[i]) begin
                        pop = pop + POP_W'(1);
                        if (cnt_q[i] == '1) ovf_d = 1'b1;
                        else                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end

                // Total is widened so a full-width strobe word cannot wrap before the clamp.
                sum = SUM_W'(total_q) + SUM_W'(pop);
                if (sum > SAT_MAX) begin
                    total_d = '1;
                    ovf_d   = 1'b1;
                end else begin
                    total_d = sum[CNT_W-1:0];
                end

                if (bus.done) begin
                    if (int'(stab_q) < STABLE) stab_d = stab_q + 8'd1;
                end else begin
                    stab_d = '0;
                end

                complete = bus.done && (int'(stab_q) == STABLE - 1);
                timeout  = (int'(cycles_q) == TIMEOUT - 1);

                if (complete) begin
                    state_d  = ((int'(total_d) == EXP_PKTS) && !ovf_d) ? S_PASS : S_FCNT;
                    finish_d = 1'b1;
                end else if (timeout) begin
                    state_d  = S_FTO;
                    finish_d = 1'b1;
                end
            end
            default: begin
                // IDLE and all terminal states: only `start` matters, and it re-arms.
                if (bus.start) begin
                    for (int unsigned i = 0; i < N_NODES; i++) cnt_d[i] = '0;
                    total_d  = '0;
                    cycles_d = '0;
                    stab_d   = '0;
                    ovf_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
        endcase
    end

    always_comb begin
        bus.rd_count = '0;
        if (int'(bus.rd_node) < N_NODES) bus.rd_count = cnt_q[bus.rd_node];
    end

    assign bus.total  = total_q;
    assign bus.cycles = cycles_q;
    assign bus.status = state_q;
    assign bus.finish = finish_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_noc_run_monitor.sv
// Scoreboard bench for noc_run_monitor: stimulus queues expected run outcomes,
// a negedge monitor pops and checks them whenever a DUT pulses `finish`.
module tb_noc_run_monitor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_run_monitor_if #(.N_NODES(16), .NODE_W(4), .CNT_W(16)) bus0 ();
    noc_run_monitor_if #(.N_NODES(16), .NODE_W(4), .CNT_W(16)) bus1 ();
    noc_run_monitor_if #(.N_NODES(16), .NODE_W(4), .CNT_W(4))  bus2 ();

    noc_run_monitor #(.N_NODES(16), .NODE_W(4), .CNT_W(16), .TIMEOUT(1024),
                      .STABLE(2), .EXP_PKTS(192)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    noc_run_monitor #(.N_NODES(16), .NODE_W(4), .CNT_W(16), .TIMEOUT(1024),
                      .STABLE(1), .EXP_PKTS(192)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    noc_run_monitor #(.N_NODES(16), .NODE_W(4), .CNT_W(4), .TIMEOUT(1024),
                      .STABLE(2), .EXP_PKTS(20))  u2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [2:0] st;
        int         total;
        int         cycles;
        logic       ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void chk(string name, int act, int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, expv);
    endfunction

    function automatic void cmp(string tag, exp_t e, logic [2:0] st, int tot, int cyc, logic ovf);
        chk({tag, "_status"}, int'(st), int'(e.st));
        chk({tag, "_total"},  tot, e.total);
        chk({tag, "_cycles"}, cyc, e.cycles);
        chk({tag, "_ovf"},    int'(ovf), int'(e.ovf));
    endfunction

    function automatic void spurious(string tag);
        n_chk++;
        $display("FAIL %s_finish: got 1 with no outcome pending, required 0", tag);
    endfunction

    always @(negedge clk) begin
        if (bus0.finish) begin
            if (q0.size() == 0) spurious("u0");
            else cmp("u0", q0.pop_front(), bus0.status, int'(bus0.total), int'(bus0.cycles), bus0.ovf);
        end
        if (bus1.finish) begin
            if (q1.size() == 0) spurious("u1");
            else cmp("u1", q1.pop_front(), bus1.status, int'(bus1.total), int'(bus1.cycles), bus1.ovf);
        end
        if (bus2.finish) begin
            if (q2.size() == 0) spurious("u2");
            else cmp("u2", q2.pop_front(), bus2.status, int'(bus2.total), int'(bus2.cycles), bus2.ovf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(logic [2:0] st, int tot, int cy, logic ov);
        exp_t e;
        e.st = st; e.total = tot; e.cycles = cy; e.ovf = ov;
        return e;
    endfunction

    function automatic logic [15:0] onehot(int p);
        logic [15:0] v;
        v = 16'h0001;
        return v << (p % 16);
    endfunction

    task automatic arm0();
        bus0.start = 1'b1; cyc(); bus0.start = 1'b0;
    endtask

    // One-hot strobes round-robin over nodes; index `skip` is left empty.
    task automatic pulses0(int npk, int skip);
        for (int p = 0; p < npk; p++) begin
            bus0.out_v = (p == skip) ? 16'h0000 : onehot(p);
            cyc();
        end
        bus0.out_v = '0;
    endtask

    task automatic rd0(int k, int expv, string name);
        bus0.rd_node = 4'(k);
        #1;
        chk(name, int'(bus0.rd_count), expv);
    endtask

    task automatic wait_term0(int maxc, output int n);
        n = 0;
        while (bus0.status == 3'b001 && n < maxc) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        bus0.start = 0; bus0.done = 0; bus0.out_v = '0; bus0.rd_node = '0;
        bus1.start = 0; bus1.done = 0; bus1.out_v = '0; bus1.rd_node = '0;
        bus2.start = 0; bus2.done = 0; bus2.out_v = '0; bus2.rd_node = '0;
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_status", int'(bus0.status), 0);
        chk("rst_total",  int'(bus0.total), 0);
        chk("rst_cycles", int'(bus0.cycles), 0);
        chk("rst_finish", int'(bus0.finish), 0);
        chk("rst_ovf",    int'(bus0.ovf), 0);
        rd0(3, 0, "rst_rd3");
        rst = 1'b0;
        cyc();

        // Normal pass: 192 packets, 12 per node, then done held.
        q0.push_back(mk(3'b010, 192, 194, 1'b0));
        arm0();
        chk("arm_status", int'(bus0.status), 1);
        pulses0(192, -1);
        bus0.done = 1'b1;
        cyc();
        chk("stab1_status", int'(bus0.status), 1);
        cyc();
        chk("pass_status", int'(bus0.status), 2);
        for (int k = 0; k < 16; k++) rd0(k, 12, "pass_rd");
        cyc();
        chk("pass_hold_status", int'(bus0.status), 2);
        chk("pass_hold_finish", int'(bus0.finish), 0);
        bus0.done = 1'b0;

        // Re-arm from PASS, then a 191-packet run with node 5 one short.
        arm0();
        chk("rearm_status", int'(bus0.status), 1);
        chk("rearm_total",  int'(bus0.total), 0);
        chk("rearm_cycles", int'(bus0.cycles), 0);
        rd0(7, 0, "rearm_rd7");
        q0.push_back(mk(3'b011, 191, 194, 1'b0));
        pulses0(192, 5);
        bus0.done = 1'b1;
        wait_term0(10, n);
        chk("fcnt_latency", n, 2);
        rd0(5, 11, "fcnt_rd5");
        rd0(4, 12, "fcnt_rd4");
        bus0.done = 1'b0;

        // Done glitch, then all 16 strobes on the completion cycle.
        arm0();
        q0.push_back(mk(3'b010, 192, 180, 1'b0));
        pulses0(176, -1);
        bus0.done = 1'b1; cyc();
        bus0.done = 1'b0; cyc();
        bus0.done = 1'b1; cyc();
        chk("glitch_status", int'(bus0.status), 1);
        bus0.out_v = 16'hFFFF; cyc();
        bus0.out_v = '0;
        chk("burst_status", int'(bus0.status), 2);
        rd0(9, 12, "burst_rd9");
        bus0.done = 1'b0;

        // Reset mid-run aborts without a finish pulse.
        arm0();
        pulses0(5, -1);
        rst = 1'b1; cyc();
        chk("abort_status", int'(bus0.status), 0);
        chk("abort_total",  int'(bus0.total), 0);
        chk("abort_finish", int'(bus0.finish), 0);
        rd0(0, 0, "abort_rd0");
        rst = 1'b0; cyc();

        // Timeout with no done.
        q0.push_back(mk(3'b100, 0, 1024, 1'b0));
        arm0();
        wait_term0(1100, n);
        chk("timeout_latency", n, 1024);
        chk("timeout_status", int'(bus0.status), 4);

        // STABLE=1: done arriving in the last allowed cycle completes instead of timing out.
        q1.push_back(mk(3'b010, 192, 1024, 1'b0));
        bus1.start = 1'b1; cyc(); bus1.start = 1'b0;
        for (int p = 0; p < 1023; p++) begin
            bus1.out_v = (p < 192) ? onehot(p) : 16'h0000;
            cyc();
        end
        bus1.out_v = '0;
        chk("late_pre_status", int'(bus1.status), 1);
        bus1.done = 1'b1; cyc();
        bus1.done = 1'b0;
        chk("late_status", int'(bus1.status), 2);

        // CNT_W=4: 20 strobes on node 0 saturate counters and set ovf.
        q2.push_back(mk(3'b011, 15, 15, 1'b1));
        bus2.start = 1'b1; cyc(); bus2.start = 1'b0;
        bus2.out_v = 16'h0001;
        repeat (20) cyc();
        bus2.out_v = '0;
        bus2.done = 1'b1; cyc(); cyc();
        bus2.done = 1'b0;
        chk("sat_status", int'(bus2.status), 3);
        bus2.rd_node = 4'd0; #1;
        chk("sat_rd0", int'(bus2.rd_count), 15);
        bus2.rd_node = 4'd1; #1;
        chk("sat_rd1", int'(bus2.rd_count), 0);
        bus2.start = 1'b1; cyc(); bus2.start = 1'b0;
        chk("sat_rearm_ovf",    int'(bus2.ovf), 0);
        chk("sat_rearm_status", int'(bus2.status), 1);
        bus2.rd_node = 4'd0; #1;
        chk("sat_rearm_rd0", int'(bus2.rd_count), 0);

        cyc(); cyc();
        chk("outcomes_consumed", q0.size() + q1.size() + q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/noc_run_monitor.md
Name: noc_run_monitor

Overview:
Synthesizable run monitor for torus NoC simulations and FPGA bring-up. It arms on `start` and counts cycles and delivered packets, per node and in total, from the network's per-node `out_v` strobes. It then declares PASS, FAIL_COUNT or FAIL_TIMEOUT once `done` has been stable for a set window or a timeout expires. It sits beside the torus instance in the top level and replaces ad-hoc cycle/finish logic, generalising it to N nodes, a configurable stability window and packet-count checking.

Parameters:
- N_NODES, 16, number of torus endpoints (X_MAX*Y_MAX); width of `out_v`.
- NODE_W, 4, index width for `rd_node`; must satisfy 2^NODE_W >= N_NODES.
- CNT_W, 16, width of per-node and total packet counters and of the cycle counter.
- TIMEOUT, 1024, cycles in RUN before FAIL_TIMEOUT.
- STABLE, 2, consecutive cycles `done` must be high to complete; legal range 1..255.
- EXP_PKTS, 192, expected total packets delivered (N_NODES*N_PACKETS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle arm/re-arm pulse
- done  in  1  network completion flag
- out_v  in  N_NODES  per-node output-valid strobes; each set bit is one delivered packet
- rd_node  in  NODE_W  per-node counter read index
- rd_count  out  CNT_W  combinational read of the counter for node `rd_node`; 0 if index >= N_NODES
- total  out  CNT_W  registered total packets counted
- cycles  out  CNT_W  registered cycles elapsed in the current/last run
- status  out  3  000 IDLE, 001 RUN, 010 PASS, 011 FAIL_COUNT, 100 FAIL_TIMEOUT
- finish  out  1  one-cycle pulse on entry to any terminal state
- ovf  out  1  sticky; set if any counter saturated during the run

Behaviour:
- Reset: state IDLE; all node counters, `total`, `cycles` and the stability counter are 0; `finish`=0 and `ovf`=0. Reset mid-run aborts immediately, with no `finish` pulse.
- IDLE: inputs are ignored except `start`. When `start`=1, next cycle the state is RUN and all counters are cleared.
- Terminal states (PASS, FAIL_COUNT, FAIL_TIMEOUT):
  - Counters and `cycles` freeze.
  - The state holds until `rst` or `start`.
  - `start` in a terminal state clears counters and `ovf`, then enters RUN. This is re-arming.
- RUN, each cycle:
  - `cycles` <= `cycles`+1, saturating.
  - For each i with out_v[i]=1, node counter i increments by 1, saturating at 2^CNT_W-1.
  - `total` <= `total` + popcount(out_v), saturating.
  - Any saturation sets `ovf`.
  - `start` during RUN is ignored.
- Stability counter, during RUN:
  - If `done`=1, it increments (capped at STABLE); otherwise it clears to 0.
  - Completion condition: `done`=1 and the stability counter == STABLE-1 in the same cycle. With STABLE=1, the first `done` cycle completes.
- On the completion cycle, compare total_next = `total` + popcount(out_v) (the beats of that cycle are included) against EXP_PKTS:
  - equal, and `ovf` stays 0 -> PASS;
  - otherwise -> FAIL_COUNT.
- Timeout: if `cycles` == TIMEOUT-1 in RUN and completion is not met that cycle -> FAIL_TIMEOUT.
- Completion and timeout in the same cycle: completion wins.
- Latency and outputs:
  - `status` changes one cycle after the deciding edge.
  - `finish` is high in exactly the first cycle `status` shows the terminal code.
  - `total`/`cycles` show the final values in that same cycle.
- `cycles` counts RUN cycles. The value in the first terminal cycle equals the number of RUN cycles, including the deciding cycle.
- `rd_count` is combinational from the counter array and is valid in all states. The counters are flops; no RAM inference is required.
- All outputs are registered except `rd_count`.

Test Plan:
- Normal pass:
  - Stimulus: reset, `start`; 192 single-bit `out_v` pulses spread over nodes (12 per node) within 300 cycles; then `done` high, held.
  - Response: after 2 `done` cycles, status=010, `finish` pulses once, total=192, rd_count(k)=12 for all k, ovf=0.
- Count mismatch:
  - Stimulus: as above but only 191 packets (node 5 gets 11).
  - Response: status=011, total=191, rd_count(5)=11.
- Timeout:
  - Stimulus: `start`, no `done`.
  - Response: exactly 1024 cycles later status=100, cycles=1024, `finish` pulses once.
  - Stimulus: `done` asserted on cycle 1023 with STABLE=1.
  - Response: PASS/FAIL_COUNT instead of timeout (completion wins).
- Done glitch:
  - Stimulus: `done` high 1 cycle, low 1 cycle, then held high.
  - Response: no completion on the glitch; completion 2 cycles after the final rise.
  - Stimulus: all 16 `out_v` bits set on the completion cycle.
  - Response: those 16 beats are included in `total`.
- Re-arm and reset:
  - Stimulus: after PASS, `start`.
  - Response: counters read 0 the next cycle, status=001, ovf cleared.
  - Stimulus: `rst` mid-RUN.
  - Response: status=000, total=0, no `finish`.
- Saturation (CNT_W=4):
  - Stimulus: 20 pulses on node 0.
  - Response: rd_count(0)=15, ovf=1, final status=011.
